// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the two-port
// memory bus arbiter. Transfer semantics: the arbiter owns the
// handshake. A requester raises req_i and keeps its first write beat
// (or nothing, for reads) on wdataN_i. grant_o names the owner for the
// whole transaction. A beat moves in exactly the cycle beat_o is high
// for the owner: a write beat is taken from wdataN_i, or a read beat is
// valid on rdata_o. done_o or err_o then pulses once. On the memory
// side, a command is valid for the single cycle m_cmd_o != NOP.
// m_resp_i marks the first response cycle; read beats follow back to
// back on m_rdata_i.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic [1:0]        req_i;
  logic [1:0]        wr_i;
  logic [ADDR_W-1:0] addr0_i;
  logic [ADDR_W-1:0] addr1_i;
  logic [15:0]       wdata0_i;
  logic [15:0]       wdata1_i;
  logic [1:0]        grant_o;
  logic [1:0]        beat_o;
  logic [15:0]       rdata_o;
  logic [1:0]        done_o;
  logic [1:0]        err_o;
  logic [1:0]        m_cmd_o;
  logic [ADDR_W-1:0] m_addr_o;
  logic [15:0]       m_wdata_o;
  logic [15:0]       m_rdata_i;
  logic              m_resp_i;

  // Arbiter side
  modport slave (
    input  req_i, wr_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    input  m_rdata_i, m_resp_i,
    output grant_o, beat_o, rdata_o, done_o, err_o,
    output m_cmd_o, m_addr_o, m_wdata_o
  );

  // Requester / memory side
  modport master (
    output req_i, wr_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    output m_rdata_i, m_resp_i,
    input  grant_o, beat_o, rdata_o, done_o, err_o,
    input  m_cmd_o, m_addr_o, m_wdata_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter giving two requesters line-sized read/write access
// to a bus-2 memory. Optional response timeout enabled by defining the
// macro ARB_TIMEOUT_EN. Without it, WAIT waits forever and err_o stays 0.
// state_o exposes the FSM state for debug.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int BEATS   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                    CLK,
  input  logic                    RESET,
  mem_bus_arbiter_if.slave        bus,
  output logic [2:0]              state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WAIT  = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_WRITE = 2'd3;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;   // 0 = requester 0, 1 = requester 1
  logic              wr_q, wr_d;         // latched command of the owner
  logic              prio_q, prio_d;     // requester that wins a tie
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        beat_q, beat_d;     // read-beat pulse
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [1:0]        m_cmd_q, m_cmd_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              win;
`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]   to_q, to_d;
`else
  // TIMEOUT only matters when the timeout counter is built.
  logic              unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    prio_d   = prio_q;
    grant_d  = grant_q;
    beat_d   = 2'b00;
    done_d   = 2'b00;
    err_d    = 2'b00;
    m_cmd_d  = CMD_NOP;
    m_addr_d = m_addr_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
`ifdef ARB_TIMEOUT_EN
    to_d     = to_q;
`endif
    // A tie goes to the priority holder; otherwise the lone requester.
    win = (bus.req_i == 2'b11) ? prio_q : bus.req_i[1];

    case (state_q)
      S_IDLE: begin
        if (|bus.req_i) begin
          owner_d  = win;
          wr_d     = bus.wr_i[win];
          grant_d  = win ? 2'b10 : 2'b01;
          prio_d   = ~win;
          m_addr_d = win ? bus.addr1_i : bus.addr0_i;
          cnt_d    = '0;
          m_cmd_d  = bus.wr_i[win] ? CMD_WRITE : CMD_READ;
          state_d  = bus.wr_i[win] ? S_WRITE : S_WAIT;
`ifdef ARB_TIMEOUT_EN
          to_d     = '0;
`endif
        end
      end
      S_WRITE: begin
        // Beat cnt_q is on the bus this cycle; the last one ends the burst.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BEATS - 1)) begin
          state_d = S_WAIT;
`ifdef ARB_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end
      S_WAIT: begin
        if (bus.m_resp_i) begin
          if (wr_q) begin
            state_d = S_DONE;
          end else begin
            rdata_d = bus.m_rdata_i;
            beat_d  = grant_q;
            cnt_d   = CNT_W'(1);
            state_d = (BEATS == 1) ? S_DONE : S_READ;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (to_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = grant_q;
          grant_d = 2'b00;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      S_READ: begin
        // Read beats stream back to back; m_resp_i is not looked at here.
        rdata_d = bus.m_rdata_i;
        beat_d  = grant_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BEATS - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = grant_q;
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // State and registered outputs; synchronous reset aborts silently.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      wr_q     <= 1'b0;
      prio_q   <= 1'b0;
      grant_q  <= 2'b00;
      beat_q   <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      m_cmd_q  <= CMD_NOP;
      m_addr_q <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
`ifdef ARB_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      prio_q   <= prio_d;
      grant_q  <= grant_d;
      beat_q   <= beat_d;
      done_q   <= done_d;
      err_q    <= err_d;
      m_cmd_q  <= m_cmd_d;
      m_addr_q <= m_addr_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
`ifdef ARB_TIMEOUT_EN
      to_q     <= to_d;
`endif
    end
  end

  // Write beats pass straight through so the owner can advance its wdata
  // on the same edge that consumes the current beat.
  assign bus.m_wdata_o = (state_q == S_WRITE) ?
                         (owner_q ? bus.wdata1_i : bus.wdata0_i) : 16'h0000;
  assign bus.beat_o    = beat_q | ((state_q == S_WRITE) ? grant_q : 2'b00);
  assign bus.grant_o   = grant_q;
  assign bus.rdata_o   = rdata_q;
  assign bus.done_o    = done_q;
  assign bus.err_o     = err_q;
  assign bus.m_cmd_o   = m_cmd_q;
  assign bus.m_addr_o  = m_addr_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed plus randomized bench for mem_bus_arbiter. Expected behaviour
// comes from a transaction-level model: who wins, which command and
// address go out, which beats move in which cycles, and when done/err
// pulse.
module tb_mem_bus_arbiter;
  localparam int ADDR_W  = 14;
  localparam int BEATS   = 8;
  localparam int TIMEOUT = 10;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [2:0] state_dbg;
  int         tests = 0;
  int         fails = 0;
  int         exp_prio = 0;   // requester that wins a tie next
  bit         in_done = 1'b0; // positioned in a done cycle with req held

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  mem_bus_arbiter #(
    .ADDR_W(ADDR_W), .BEATS(BEATS), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .state_o(state_dbg)
  );

  // Clock
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_wdata(input int w, input logic [15:0] v);
    if (w == 1) bus.wdata1_i = v;
    else        bus.wdata0_i = v;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, bus.grant_o, 0);
    chk({tag, "_beat"},  bus.beat_o, 0);
    chk({tag, "_done"},  bus.done_o, 0);
    chk({tag, "_err"},   bus.err_o, 0);
    chk({tag, "_cmd"},   bus.m_cmd_o, 0);
    chk({tag, "_addr"},  bus.m_addr_o, 0);
    chk({tag, "_wdata"}, bus.m_wdata_o, 0);
    chk({tag, "_rdata"}, bus.rdata_o, 0);
  endtask

  // One complete transaction. dbase < 0 picks random data. chain keeps
  // req_i held through the done cycle so the next call arbitrates there.
  // rst_at >= 0 asserts RESET while read beat rst_at is on rdata_o.
  task automatic txn(input logic [1:0] req, input logic [1:0] wr,
                     input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                     input int lat, input int dbase, input bit chain, input int rst_at);
    int                w;
    logic [1:0]        oh;
    bit                is_wr;
    logic [ADDR_W-1:0] ea;
    logic [15:0]       d[BEATS];
    w     = (req == 2'b11) ? exp_prio : int'(req[1]);
    oh    = (w == 1) ? 2'b10 : 2'b01;
    is_wr = wr[w];
    ea    = (w == 1) ? a1 : a0;
    for (int i = 0; i < BEATS; i++)
      d[i] = (dbase >= 0) ? 16'(dbase + i) : 16'($urandom);
    bus.req_i    = req;
    bus.wr_i     = wr;
    bus.addr0_i  = a0;
    bus.addr1_i  = a1;
    bus.wdata0_i = 16'($urandom);
    bus.wdata1_i = 16'($urandom);
    if (is_wr) set_wdata(w, d[0]);
    bus.m_resp_i = 1'b0;
    if (!in_done) begin
      @(negedge CLK);
      chk("pre_grant", bus.grant_o, 0);
    end
    in_done = 1'b0;
    tick();
    exp_prio = 1 - w;

    if (is_wr) begin
      for (int k = 0; k < BEATS; k++) begin
        set_wdata(w, d[k]);
        if (!chain) bus.req_i = 2'($urandom);
        @(negedge CLK);
        chk("wr_grant", bus.grant_o, oh);
        chk("wr_data",  bus.m_wdata_o, d[k]);
        chk("wr_beat",  bus.beat_o, oh);
        chk("wr_cmd",   bus.m_cmd_o, (k == 0) ? 3 : 0);
        if (k == 0) chk("wr_addr", bus.m_addr_o, ea);
        tick();
      end
      for (int c = 0; c <= lat; c++) begin
        bus.m_resp_i = (c == lat);
        @(negedge CLK);
        chk("wr_wait_grant", bus.grant_o, oh);
        chk("wr_wait_beat",  bus.beat_o, 0);
        tick();
      end
      if (!chain) bus.req_i = 2'b00;
      bus.m_resp_i = 1'($urandom);
      @(negedge CLK);
      chk("wr_done_early", bus.done_o, 0);
      chk("wr_done_grant", bus.grant_o, oh);
      tick();
    end else begin
      for (int c = 0; c <= lat; c++) begin
        bus.m_resp_i  = (c == lat);
        bus.m_rdata_i = (c == lat) ? d[0] : 16'($urandom);
        if (!chain) bus.req_i = 2'($urandom);
        @(negedge CLK);
        chk("rd_wait_grant", bus.grant_o, oh);
        chk("rd_wait_beat",  bus.beat_o, 0);
        chk("rd_wait_cmd",   bus.m_cmd_o, (c == 0) ? 2 : 0);
        if (c == 0) chk("rd_addr", bus.m_addr_o, ea);
        tick();
      end
      for (int k = 0; k < BEATS; k++) begin
        bus.m_rdata_i = (k < BEATS - 1) ? d[k+1] : 16'($urandom);
        bus.m_resp_i  = 1'($urandom);
        if (k == BEATS - 1 && !chain) bus.req_i = 2'b00;
        if (k == rst_at) RESET = 1'b1;
        @(negedge CLK);
        chk("rd_beat",  bus.beat_o, oh);
        chk("rd_data",  bus.rdata_o, d[k]);
        chk("rd_grant", bus.grant_o, oh);
        chk("rd_done_early", bus.done_o, 0);
        tick();
        if (k == rst_at) begin
          RESET        = 1'b0;
          bus.req_i    = 2'b00;
          bus.m_resp_i = 1'b0;
          exp_prio     = 0;
          @(negedge CLK);
          chk_reset_outputs("mid_rst");
          for (int j = 0; j < 3; j++) begin
            tick();
            @(negedge CLK);
            chk("post_rst_done", bus.done_o, 0);
            chk("post_rst_err",  bus.err_o, 0);
          end
          tick();
          return;
        end
      end
    end
    bus.m_resp_i = 1'b0;
    @(negedge CLK);
    chk("done_pulse", bus.done_o, oh);
    chk("done_grant", bus.grant_o, 0);
    chk("done_err",   bus.err_o, 0);
    chk("done_beat",  bus.beat_o, 0);
    if (chain) in_done = 1'b1;
    else       tick();
  endtask

  initial begin
    // Reset
    RESET         = 1'b1;
    bus.req_i     = 2'b00;
    bus.wr_i      = 2'b00;
    bus.addr0_i   = '0;
    bus.addr1_i   = '0;
    bus.wdata0_i  = '0;
    bus.wdata1_i  = '0;
    bus.m_rdata_i = '0;
    bus.m_resp_i  = 1'b0;
    repeat (3) tick();
    @(negedge CLK);
    chk_reset_outputs("reset");
    RESET = 1'b0;
    tick();

    // Read only, requester 0
    txn(2'b01, 2'b00, 14'h002A, ADDR_W'($urandom), 2, 'h0100, 1'b0, -1);
    // Write only, requester 1
    txn(2'b10, 2'b10, ADDR_W'($urandom), ADDR_W'($urandom), 3, 'h00A0, 1'b0, -1);

    // Spurious response while idle
    bus.req_i    = 2'b00;
    bus.m_resp_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.m_rdata_i = 16'($urandom);
      @(negedge CLK);
      chk("spur_beat",  bus.beat_o, 0);
      chk("spur_done",  bus.done_o, 0);
      chk("spur_grant", bus.grant_o, 0);
      chk("spur_cmd",   bus.m_cmd_o, 0);
      tick();
    end
    bus.m_resp_i = 1'b0;

    // Both requesting, held across back-to-back transactions: 0, 1, 0
    txn(2'b11, 2'($urandom), ADDR_W'($urandom), ADDR_W'($urandom), 1, -1, 1'b1, -1);
    txn(2'b11, 2'($urandom), ADDR_W'($urandom), ADDR_W'($urandom), 0, -1, 1'b1, -1);
    txn(2'b11, 2'($urandom), ADDR_W'($urandom), ADDR_W'($urandom), 2, -1, 1'b0, -1);

    // Randomized mix
    for (int n = 0; n < 12; n++)
      txn(2'($urandom_range(1, 3)), 2'($urandom), ADDR_W'($urandom), ADDR_W'($urandom),
          int'($urandom_range(0, 4)), -1, 1'($urandom), -1);
    if (in_done) begin
      bus.req_i = 2'b00;
      in_done   = 1'b0;
      tick();
    end

    // Reset during read beat 3, then a normal grant to requester 1
    txn(2'b01, 2'b00, ADDR_W'($urandom), ADDR_W'($urandom), 1, -1, 1'b0, 3);
    txn(2'b10, 2'($urandom), ADDR_W'($urandom), ADDR_W'($urandom), 1, -1, 1'b0, -1);

    // Silent memory after a read grant
    bus.req_i    = 2'b01;
    bus.wr_i     = 2'b00;
    bus.addr0_i  = ADDR_W'($urandom);
    bus.m_resp_i = 1'b0;
    @(negedge CLK);
    chk("to_pre_grant", bus.grant_o, 0);
    tick();
    bus.req_i = 2'b00;
    exp_prio  = 1;
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge CLK);
      chk("to_wait_err",   bus.err_o, 0);
      chk("to_wait_grant", bus.grant_o, 2'b01);
      tick();
    end
    @(negedge CLK);
    chk("to_err",   bus.err_o, 2'b01);
    chk("to_grant", bus.grant_o, 0);
    chk("to_done",  bus.done_o, 0);
    tick();
    @(negedge CLK);
    chk("to_err_end", bus.err_o, 0);
    tick();
`else
    for (int c = 1; c <= 300; c++) begin
      @(negedge CLK);
      if (c % 50 == 0) begin
        chk("wait_grant", bus.grant_o, 2'b01);
        chk("wait_err",   bus.err_o, 0);
        chk("wait_done",  bus.done_o, 0);
      end
      tick();
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    exp_prio = 0;
    @(negedge CLK);
    chk_reset_outputs("wait_rst");
    tick();
`endif
    // Arbiter still serves normally afterwards
    txn(2'b01, 2'($urandom), ADDR_W'($urandom), ADDR_W'($urandom), 1, -1, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, width of the line address carried on the bus-2 address lines.
REQ-002 Parameter BEATS, default 8, number of 16-bit data beats per cache line (CACHE_LINE_SIZE/2).
REQ-003 Parameter TIMEOUT, default 255, cycles allowed for the memory response before abort.
REQ-004 CLK  in  1  sole clock, all state updates on the rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 req_i  in  2  per-requester transaction request, level, bit 0 = requester 0.
REQ-007 wr_i  in  2  per-requester command qualifier: 1 = C2_WRITE_LINE, 0 = C2_READ_LINE.
REQ-008 addr0_i, addr1_i  in  ADDR_W each  line address of requester 0 and requester 1.
REQ-009 wdata0_i, wdata1_i  in  16 each  current write beat of requester 0 and requester 1.
REQ-010 grant_o  out  2  one-hot owner of the memory bus, held for the whole transaction.
REQ-011 beat_o  out  2  one-cycle pulse to the owner: write beat consumed, or read beat valid on rdata_o.
REQ-012 rdata_o  out  16  read beat forwarded from memory.
REQ-013 done_o, err_o  out  2 each  one-cycle completion pulse and timeout pulse, per requester.
REQ-014 m_cmd_o  out  2  bus-2 command: NOP=0, RESPONSE=1, READ_LINE=2, WRITE_LINE=3.
REQ-015 m_addr_o  out  ADDR_W; m_wdata_o  out  16; m_rdata_i  in  16; m_resp_i  in  1: memory-side address, write data, read data and response strobe.

Function
REQ-016 The FSM SHALL have states IDLE, WRITE, WAIT, READ and DONE.
REQ-017 In IDLE with any req_i set, the arbiter SHALL grant round-robin: on simultaneous requests, the requester not served last wins; after reset, requester 0 has priority.
REQ-018 On grant, the arbiter SHALL latch the winner's address and command, set grant_o, and drive m_cmd_o for exactly one cycle.
REQ-019 On read grant: m_cmd_o=READ_LINE and m_addr_o=the latched address for one cycle, then m_cmd_o=NOP and the FSM goes to WAIT.
REQ-020 On write grant: m_cmd_o=WRITE_LINE in the first cycle with beat 0 on m_wdata_o; beats 1..BEATS-1 follow on consecutive cycles. The FSM stays in WRITE until BEATS beats are sent, then goes to WAIT.
REQ-021 Each write beat SHALL produce one beat_o pulse to the owner in the cycle the beat is driven, so the owner advances its wdata.
REQ-022 WAIT (read): the first cycle with m_resp_i=1 SHALL capture beat 0. The FSM goes to READ. Beats arrive on BEATS consecutive cycles, each forwarded to rdata_o with a beat_o pulse one cycle after capture.
REQ-023 WAIT (write): m_resp_i=1 SHALL move the FSM to DONE.
REQ-024 DONE SHALL last one cycle: done_o pulses for the owner, grant_o clears, and the FSM returns to IDLE. A new grant is possible in the following cycle.
REQ-025 The beat counter SHALL be clog2(BEATS) bits wide and reset to 0 at every grant.
REQ-026 m_resp_i outside WAIT/READ, and req_i changes of the owner mid-transaction, SHALL be ignored.
REQ-027 A requester still asserting req_i in DONE SHALL be re-eligible in the next arbitration under round-robin rules.

Reset
REQ-028 RESET SHALL force IDLE, grant_o=0, beat_o=0, done_o=0, err_o=0, m_cmd_o=NOP, m_addr_o=0, m_wdata_o=0, rdata_o=0, beat counter=0 and round-robin pointer=requester 0.
REQ-029 RESET in any state SHALL abort the transaction without a done_o or err_o pulse.

Configuration
REQ-030 With ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT. After TIMEOUT cycles without m_resp_i, err_o pulses for the owner, grant_o clears, and the FSM returns to IDLE with no done_o. Without the macro, WAIT waits indefinitely and err_o is tied to 0.

Verification
REQ-031 Read only: req_i=01, wr_i=0, addr0_i=0x2A. Required: grant_o=01 and one cycle of m_cmd_o=2, m_addr_o=0x2A. Memory responds with beats 0x0100..0x0107. Required: 8 beat_o[0] pulses with the same data, then done_o=01.
REQ-032 Write only: req_i=10, wr_i=10, wdata1_i stepping 0xA0..0xA7. Required: m_cmd_o=3 on the first beat, 8 consecutive m_wdata_o beats, then m_resp_i, then done_o=10.
REQ-033 Simultaneous requests: req_i=11 held across two transactions. Required grant order 0, 1; a third arbitration grants 0.
REQ-034 RESET asserted during the READ state at beat 3. Required next cycle: all outputs at reset values and no done_o; the next req_i=10 is granted normally.
REQ-035 ARB_TIMEOUT_EN defined, TIMEOUT=10, memory silent. Required: err_o=01 pulse 10 cycles after entering WAIT, then IDLE. Without the macro: the arbiter is still in WAIT after 300 cycles.
REQ-036 Spurious m_resp_i=1 in IDLE. Required: no beat_o, done_o or state change.
